// File: rtl/banco_registro_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | banco_registro_ctrl_if : write-port / scan bus of the bank control |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface banco_registro_ctrl_if #(
  parameter int BIT_ADDR = 8,
  parameter int BIT_DATO = 4
);
  logic                clear_req;
  logic                req0_valid;
  logic [BIT_ADDR-1:0] req0_addr;
  logic [BIT_DATO-1:0] req0_dat;
  logic                req0_ready;
  logic                req1_valid;
  logic [BIT_ADDR-1:0] req1_addr;
  logic [BIT_DATO-1:0] req1_dat;
  logic                req1_ready;
  logic                reg_write;
  logic [BIT_ADDR-1:0] addr_w;
  logic [BIT_DATO-1:0] dat_w;
  logic                busy;
  logic [BIT_ADDR-1:0] scan_addr;
  logic                scan_tick;

  modport master (
    output clear_req, req0_valid, req0_addr, req0_dat,
    output req1_valid, req1_addr, req1_dat,
    input  req0_ready, req1_ready, reg_write, addr_w, dat_w,
    input  busy, scan_addr, scan_tick
  );

  modport slave (
    input  clear_req, req0_valid, req0_addr, req0_dat,
    input  req1_valid, req1_addr, req1_dat,
    output req0_ready, req1_ready, reg_write, addr_w, dat_w,
    output busy, scan_addr, scan_tick
  );
endinterface
`default_nettype wire

// File: rtl/banco_registro_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | banco_registro_ctrl : bank clear sequencer, RR write arbiter, scan |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module banco_registro_ctrl #(
  parameter int BIT_ADDR = 8,
  parameter int BIT_DATO = 4,
  parameter int SCAN_DIV = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  banco_registro_ctrl_if.slave  bus
);

  localparam int                  c_DIV_W     = $clog2(SCAN_DIV);
  localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(SCAN_DIV - 1);
  localparam logic [BIT_ADDR-1:0] c_LAST_ADDR = {BIT_ADDR{1'b1}};

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t              r_state, w_stateNext;
  logic [BIT_ADDR-1:0] r_clrPtr, w_clrPtrNext;
  logic                r_lastGrant, w_lastGrantNext;
  logic                r_regWrite, w_regWriteNext;
  logic [BIT_ADDR-1:0] r_addrW, w_addrWNext;
  logic [BIT_DATO-1:0] r_datW, w_datWNext;
  logic                r_busy;
  logic                w_grant0, w_grant1;
  logic [c_DIV_W-1:0]  r_div;
  logic [BIT_ADDR-1:0] r_scanAddr;
  logic                r_scanTick;

  always_comb begin
    w_stateNext     = r_state;
    w_clrPtrNext    = r_clrPtr;
    w_lastGrantNext = r_lastGrant;
    w_regWriteNext  = 1'b0;
    w_addrWNext     = r_addrW;
    w_datWNext      = r_datW;
    w_grant0        = 1'b0;
    w_grant1        = 1'b0;
    case (r_state)
      CLEAR: begin
        w_regWriteNext = 1'b1;
        w_addrWNext    = r_clrPtr;
        w_datWNext     = '0;
        w_clrPtrNext   = r_clrPtr + 1'b1;
        if (r_clrPtr == c_LAST_ADDR)
          w_stateNext = IDLE;
      end
      IDLE: begin
        if (bus.clear_req) begin
          w_stateNext  = CLEAR;
          w_clrPtrNext = '0;
        // r_lastGrant=1 means requester 1 was served last, so 0 wins a tie
        end else if (bus.req0_valid && (!bus.req1_valid || r_lastGrant)) begin
          w_grant0        = 1'b1;
          w_lastGrantNext = 1'b0;
          w_regWriteNext  = 1'b1;
          w_addrWNext     = bus.req0_addr;
          w_datWNext      = bus.req0_dat;
        end else if (bus.req1_valid) begin
          w_grant1        = 1'b1;
          w_lastGrantNext = 1'b1;
          w_regWriteNext  = 1'b1;
          w_addrWNext     = bus.req1_addr;
          w_datWNext      = bus.req1_dat;
        end
      end
      default: w_stateNext = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= CLEAR;
      r_clrPtr    <= '0;
      r_lastGrant <= 1'b1;
      r_regWrite  <= 1'b0;
      r_addrW     <= '0;
      r_datW      <= '0;
      r_busy      <= 1'b1;
    end else begin
      r_state     <= w_stateNext;
      r_clrPtr    <= w_clrPtrNext;
      r_lastGrant <= w_lastGrantNext;
      r_regWrite  <= w_regWriteNext;
      r_addrW     <= w_addrWNext;
      r_datW      <= w_datWNext;
      // Stays high until the last clear write has left the registered port
      r_busy      <= (r_state == CLEAR) || (w_stateNext == CLEAR);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div      <= '0;
      r_scanAddr <= '0;
      r_scanTick <= 1'b0;
    end else if (r_div == c_DIV_LAST) begin
      r_div      <= '0;
      r_scanAddr <= r_scanAddr + 1'b1;
      r_scanTick <= 1'b1;
    end else begin
      r_div      <= r_div + 1'b1;
      r_scanTick <= 1'b0;
    end
  end

  assign bus.req0_ready = w_grant0;
  assign bus.req1_ready = w_grant1;
  assign bus.reg_write  = r_regWrite;
  assign bus.addr_w     = r_addrW;
  assign bus.dat_w      = r_datW;
  assign bus.busy       = r_busy;
  assign bus.scan_addr  = r_scanAddr;
  assign bus.scan_tick  = r_scanTick;

endmodule
`default_nettype wire
